// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller and its buffer.
// The buffer entry pairs each fetched word with the PC it came from.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  fetch_entry_t               din,
   input  logic                       pop,
   input  logic                       flush,
   output fetch_entry_t               head,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign valid  = (count != '0);
   assign do_pop = pop && valid;
   // Head reads as zero when empty so decode never sees stale words.
   assign head   = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !do_pop)
            count <= count + CW'(1);
         else if (!push && do_pop)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem read at a time,
// responses buffered with their PC for the decode stage.
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i
);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   fetch_state_t  state;
   fetch_state_t  state_nxt;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          buf_valid;
   logic          room_after;
   fetch_entry_t  din;
   fetch_entry_t  head;

   assign din = '{pc: fetch_pc, instr: imem_rdata_i};

   fetch_fifo #(
      .DEPTH(BUF_DEPTH)
   ) u_fifo (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .push (push),
      .din  (din),
      .pop  (pop),
      .flush(redirect_valid_i),
      .head (head),
      .valid(buf_valid),
      .count(count)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         state <= S_REQ;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         fetch_pc <= RESET_PC;
      else if (redirect_valid_i)
         fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      else if (push)
         fetch_pc <= pc_incr(fetch_pc);
   end

   // A pop alongside the push keeps occupancy unchanged.
   assign room_after = (int'(count) + (pop ? 0 : 1)) < BUF_DEPTH;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_REQ:
            state_nxt = redirect_valid_i ? S_REQ : S_WAIT;
         S_WAIT: begin
            if (redirect_valid_i)
               state_nxt = imem_rvalid_i ? S_REQ : S_DISCARD;
            else if (imem_rvalid_i)
               state_nxt = room_after ? S_REQ : S_HOLD;
         end
         S_HOLD:
            if (redirect_valid_i || pop)
               state_nxt = S_REQ;
         S_DISCARD:
            if (imem_rvalid_i)
               state_nxt = S_REQ;
         default:
            state_nxt = S_REQ;
      endcase
   end

   // Request is masked while reset is held so the bus stays quiet.
   always_comb begin
      imem_req_o = 1'b0;
      push       = 1'b0;
      unique case (state)
         S_REQ:   imem_req_o = rst_ni && !redirect_valid_i;
         S_WAIT:  push = imem_rvalid_i && !redirect_valid_i;
         default: ;
      endcase
   end

   assign pop           = buf_valid && instr_ready_i && !redirect_valid_i;
   assign imem_addr_o   = fetch_pc;
   assign instr_valid_o = buf_valid;
   assign instr_o       = head.instr;
   assign instr_pc_o    = head.pc;

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: BUF_DEPTH, 2, fetch buffer entries; legal values 2 or 4.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 redirect_valid_i  input  1  branch/jump redirect from execute or predictor.
REQ-006 redirect_pc_i  input  32  redirect target; bits [1:0] ignored, treated as 00.
REQ-007 imem_req_o  output  1  instruction memory read request, one-cycle pulse.
REQ-008 imem_addr_o  output  32  word-aligned read address, valid while imem_req_o=1.
REQ-009 imem_rvalid_i  input  1  read data valid; arrives 1..N cycles after request.
REQ-010 imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
REQ-011 instr_valid_o  output  1  buffer head holds an instruction for decode.
REQ-012 instr_o  output  32  buffer head instruction.
REQ-013 instr_pc_o  output  32  PC of buffer head instruction.
REQ-014 instr_ready_i  input  1  decode accepts head; pop when instr_valid_o & instr_ready_i.

Function
REQ-015 FSM states: S_REQ, S_WAIT, S_HOLD, S_DISCARD; reset state S_REQ.
REQ-016 S_REQ: imem_req_o=1, imem_addr_o=fetch_pc, go S_WAIT; only entered when occupancy < BUF_DEPTH.
REQ-017 S_WAIT: on imem_rvalid_i, push {fetch_pc, imem_rdata_i}, fetch_pc += 4, go S_REQ if occupancy after push and pop < BUF_DEPTH, else S_HOLD.
REQ-018 S_HOLD: no request; go S_REQ in the cycle after a pop frees a slot.
REQ-019 At most one outstanding memory request at any time.
REQ-020 Pushed entry visible on instr_valid_o the cycle after imem_rvalid_i.
REQ-021 Push and pop in same cycle: both occur, occupancy unchanged.
REQ-022 Redirect in S_REQ/S_HOLD: buffer flushed, fetch_pc=redirect target, next state S_REQ; redirect in S_REQ suppresses that cycle's request (imem_req_o=0).
REQ-023 Redirect in S_WAIT without imem_rvalid_i: flush buffer, load fetch_pc, go S_DISCARD.
REQ-024 Redirect in S_WAIT with imem_rvalid_i same cycle: response dropped, flush, load fetch_pc, go S_REQ.
REQ-025 S_DISCARD: drop the arriving response, no push, go S_REQ; redirect here reloads fetch_pc, stays S_DISCARD unless imem_rvalid_i same cycle (then S_REQ).
REQ-026 Redirect and pop same cycle: redirect wins, buffer empty next cycle, instr_valid_o=0.
REQ-027 fetch_pc increment wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-028 imem_rvalid_i outside S_WAIT/S_DISCARD is ignored.

Reset
REQ-029 During reset: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, buffer empty, fetch_pc=RESET_PC.
REQ-030 First request issued in first clock edge cycle after rst_ni deasserts.
REQ-031 Reset mid-transaction abandons outstanding request; late imem_rvalid_i after reset, before new request, ignored.

Structure
REQ-032 Shared package fetch_pkg holds state enum, fetch_entry_t {pc, instr} struct, RESET_PC default.
REQ-033 One sub-module fetch_fifo (parameterised depth, push/pop/flush, occupancy out, async active-low reset).

Verification
REQ-034 Reset RESET_PC=0, 1-cycle memory, instr_ready_i=1: requests at 0x0,0x4,0x8 every 2 cycles; instr_pc_o sequence 0x0,0x4,0x8, data matches memory.
REQ-035 instr_ready_i=0 after reset, BUF_DEPTH=2: two pushes (0x0,0x4), FSM in S_HOLD, no further imem_req_o; raise ready -> request for 0x8 one cycle after first pop.
REQ-036 3-cycle memory latency, redirect to 0x100 one cycle after request to 0x8: old response dropped, next request addr 0x100, first instr_pc_o 0x100.
REQ-037 Redirect to 0x203 coincident with imem_rvalid_i: data dropped, next imem_addr_o 0x200.
REQ-038 fetch_pc redirected to 0xFFFF_FFFC: following request address 0x0000_0000.
REQ-039 rst_ni asserted while waiting, rvalid arrives during reset: outputs at reset values, first post-reset request at RESET_PC, no stale push.
